// File: rtl/zpu_io_pkg.sv
// Shared definitions for the ZPU IO-space UART: register offsets, STATUS layout,
// engine state encodings and the divisor clamp.
package zpu_io_pkg;

    localparam logic [3:0] REG_DATA    = 4'd0;
    localparam logic [3:0] REG_STATUS  = 4'd4;
    localparam logic [3:0] REG_DIVISOR = 4'd8;

    localparam int ST_RX_VALID     = 0;
    localparam int ST_RX_OVERRUN   = 1;
    localparam int ST_TX_DROP      = 2;
    localparam int ST_FRAME_ERR    = 3;
    localparam int ST_TX_IDLE      = 4;
    localparam int ST_TX_READY     = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    localparam logic [31:0] TX_READY_MASK = 32'h100;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Shorter bit periods leave no room for the half-bit resample point.
    function automatic logic [15:0] clamp_div(input logic [15:0] i_div);
        return (i_div < DIV_MIN) ? DIV_MIN : i_div;
    endfunction

endpackage

// File: rtl/zpu_io_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push while full is accepted only
// when a pop happens on the same edge.
module zpu_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/zpu_io_uart.sv
// Memory-mapped UART for the ZPU IO space: DATA/STATUS/DIVISOR registers,
// buffered TX/RX, sticky error flags and a level interrupt.
//
// TX state | meaning
// IDLE     | line high, waiting for a byte in the TX FIFO
// START    | driving start bit (0) for one bit period
// DATA     | shifting 8 bits LSB first
// STOP     | driving stop bit (1)
//
// RX state | meaning
// IDLE     | waiting for a falling edge on the synchronised line
// START    | waiting half a bit, then confirming the start bit
// DATA     | sampling 8 bits mid-bit
// STOP     | sampling the stop bit, then push or flag frame error
module zpu_io_uart import zpu_io_pkg::*; #(
    parameter int                WORD_SIZE = 32,
    parameter int                ADDR_W    = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 27'h80a000c,
    parameter int                TX_DEPTH  = 16,
    parameter int                RX_DEPTH  = 16,
    parameter logic [15:0]       DIV_RESET = 16'd868
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_SIZE-1:0] mem_write,
    input  logic                 io_writeEnable,
    input  logic                 io_readEnable,
    output logic                 io_busy,
    output logic [WORD_SIZE-1:0] io_mem_read,
    output logic                 uart_txd,
    input  logic                 uart_rxd,
    output logic                 irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    localparam logic [ADDR_W-1:0] A_DATA    = BASE_ADDR + ADDR_W'(REG_DATA);
    localparam logic [ADDR_W-1:0] A_STATUS  = BASE_ADDR + ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_DIVISOR = BASE_ADDR + ADDR_W'(REG_DIVISOR);

    logic w_hit_data, w_hit_status, w_hit_div;
    logic w_rd_data, w_rd_status;
    logic w_wr_data, w_wr_status, w_wr_div;

    assign w_hit_data   = (mem_addr == A_DATA);
    assign w_hit_status = (mem_addr == A_STATUS);
    assign w_hit_div    = (mem_addr == A_DIVISOR);
    assign w_rd_data    = io_readEnable  && w_hit_data;
    assign w_rd_status  = io_readEnable  && w_hit_status;
    assign w_wr_data    = io_writeEnable && w_hit_data;
    assign w_wr_status  = io_writeEnable && w_hit_status;
    assign w_wr_div     = io_writeEnable && w_hit_div;

    logic [WORD_SIZE-1:0] r_rd_data;
    logic [15:0]          r_div;
    logic                 r_tx_ie;
    logic                 r_rx_overrun;
    logic                 r_tx_drop;
    logic                 r_frame_err;

    logic [7:0]       w_tx_head;
    logic             w_tx_full, w_tx_empty, w_tx_pop;
    logic [TX_AW:0]   w_tx_count;
    logic [7:0]       w_rx_head;
    logic             w_rx_full, w_rx_empty, w_rx_pop, w_rx_push;
    logic [RX_AW:0]   w_rx_count;
    logic [7:0]       w_rx_byte;
    logic             w_ferr_set;

    assign w_rx_pop = w_rd_data && !w_rx_empty;

    zpu_io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .areset  (areset),
        .i_push  (w_wr_data),
        .i_data  (mem_write[7:0]),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    zpu_io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .areset  (areset),
        .i_push  (w_rx_push),
        .i_data  (w_rx_byte),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // ---------------- TX engine ----------------
    tx_state_t   r_tx_state, w_tx_state_nx;
    logic [15:0] r_tx_cnt, w_tx_cnt_nx;
    logic [15:0] r_tx_div, w_tx_div_nx;
    logic [7:0]  r_tx_shift, w_tx_shift_nx;
    logic [2:0]  r_tx_bit, w_tx_bit_nx;
    logic        r_txd, w_txd_nx;
    logic        w_tx_tc;
    logic        w_tx_idle;

    assign w_tx_tc   = (r_tx_cnt == 16'd0);
    assign w_tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_div   <= w_tx_div_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_txd      <= w_txd_nx;
        end
    end

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_div_nx   = r_tx_div;
        w_tx_shift_nx = r_tx_shift;
        w_tx_bit_nx   = r_tx_bit;
        w_txd_nx      = r_txd;
        w_tx_pop      = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                w_txd_nx = 1'b1;
                if (!w_tx_empty) begin
                    // Divisor is latched here so a mid-frame write cannot stretch bits.
                    w_tx_pop      = 1'b1;
                    w_tx_state_nx = TX_START;
                    w_tx_div_nx   = r_div;
                    w_tx_cnt_nx   = r_div - 16'd1;
                    w_tx_shift_nx = w_tx_head;
                    w_txd_nx      = 1'b0;
                end
            end
            TX_START: begin
                if (!w_tx_tc) begin
                    w_tx_cnt_nx = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_state_nx = TX_DATA;
                    w_tx_cnt_nx   = r_tx_div - 16'd1;
                    w_tx_bit_nx   = 3'd0;
                    w_txd_nx      = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (!w_tx_tc) begin
                    w_tx_cnt_nx = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_cnt_nx = r_tx_div - 16'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = TX_STOP;
                        w_txd_nx      = 1'b1;
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + 3'd1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                        w_txd_nx      = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (!w_tx_tc) begin
                    w_tx_cnt_nx = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_state_nx = TX_IDLE;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
                w_txd_nx      = 1'b1;
            end
        endcase
    end

    // ---------------- RX engine ----------------
    rx_state_t   r_rx_state, w_rx_state_nx;
    logic [15:0] r_rx_cnt, w_rx_cnt_nx;
    logic [15:0] r_rx_div, w_rx_div_nx;
    logic [7:0]  r_rx_shift, w_rx_shift_nx;
    logic [2:0]  r_rx_bit, w_rx_bit_nx;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic        w_rx_tc;
    logic        w_rx_fall;

    assign w_rx_tc   = (r_rx_cnt == 16'd0);
    assign w_rx_fall = r_rx_s3 && !r_rx_s2;
    assign w_rx_byte = r_rx_shift;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= '0;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_s1    <= uart_rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_div   <= w_rx_div_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_bit   <= w_rx_bit_nx;
        end
    end

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_div_nx   = r_rx_div;
        w_rx_shift_nx = r_rx_shift;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_push     = 1'b0;
        w_ferr_set    = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nx = RX_START;
                    w_rx_div_nx   = r_div;
                    w_rx_cnt_nx   = (r_div >> 1) - 16'd1;
                end
            end
            RX_START: begin
                if (!w_rx_tc) begin
                    w_rx_cnt_nx = r_rx_cnt - 16'd1;
                end else if (r_rx_s2) begin
                    w_rx_state_nx = RX_IDLE;
                end else begin
                    w_rx_state_nx = RX_DATA;
                    w_rx_cnt_nx   = r_rx_div - 16'd1;
                    w_rx_bit_nx   = 3'd0;
                end
            end
            RX_DATA: begin
                if (!w_rx_tc) begin
                    w_rx_cnt_nx = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_nx   = r_rx_div - 16'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
                    else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (!w_rx_tc) begin
                    w_rx_cnt_nx = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_state_nx = RX_IDLE;
                    w_rx_push     = r_rx_s2;
                    w_ferr_set    = !r_rx_s2;
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    // ---------------- registers and read path ----------------
    logic                 w_overrun_set, w_drop_set;
    logic [31:0]          w_status;
    logic [WORD_SIZE-1:0] w_rd_value;

    assign w_overrun_set = w_rx_push && w_rx_full && !w_rx_pop;
    assign w_drop_set    = w_wr_data && w_tx_full && !w_tx_pop;

    always_comb begin
        w_status                           = '0;
        w_status[ST_RX_VALID]              = !w_rx_empty;
        w_status[ST_RX_OVERRUN]            = r_rx_overrun;
        w_status[ST_TX_DROP]               = r_tx_drop;
        w_status[ST_FRAME_ERR]             = r_frame_err;
        w_status[ST_TX_IDLE]               = w_tx_idle;
        w_status[ST_TX_COUNT_LSB +: 8]     = 8'(w_tx_count);
        if (!w_tx_full) w_status = w_status | TX_READY_MASK;
    end

    always_comb begin
        w_rd_value = '0;
        if (w_hit_data) begin
            if (!w_rx_empty) w_rd_value = WORD_SIZE'(w_rx_head);
        end else if (w_hit_status) begin
            w_rd_value = WORD_SIZE'(w_status);
        end else if (w_hit_div) begin
            w_rd_value = WORD_SIZE'(r_div);
        end
    end

    // A flag raised on the same edge as a clearing STATUS read stays set.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_rd_data    <= '0;
            r_div        <= clamp_div(DIV_RESET);
            r_tx_ie      <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_tx_drop    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (io_readEnable) r_rd_data <= w_rd_value;
            if (w_wr_div)      r_div     <= clamp_div(mem_write[15:0]);
            if (w_wr_status)   r_tx_ie   <= mem_write[0];
            r_rx_overrun <= w_overrun_set | (r_rx_overrun & ~w_rd_status);
            r_tx_drop    <= w_drop_set    | (r_tx_drop    & ~w_rd_status);
            r_frame_err  <= w_ferr_set    | (r_frame_err  & ~w_rd_status);
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = ^{mem_write, w_rx_count};

    assign io_busy     = io_readEnable;
    assign io_mem_read = r_rd_data;
    assign uart_txd    = r_txd;
    assign irq         = !w_rx_empty || (w_tx_empty && r_tx_ie);

endmodule
